aes128_enc_iter: RTL and testbench
==================================

Name: aes128_enc_iter

Overview:
Iterative AES-128 encryption engine that wraps the per-round datapath (RoundKeyGenerator, ByteSubstitution, ShiftRows, MixColumns) in a registered state/key loop.
- Accepts one plaintext/key pair through a valid/ready handshake.
- Applies the initial AddRoundKey, runs rounds 1-9 one per cycle, then the final round without MixColumns.
- Presents the ciphertext through a valid/ready output handshake.
- Sits between the host/bus interface and the round datapath; it is the sequencer that feeds and consumes the round stage.

Parameters:
NR, 10, number of AES rounds (fixed for AES-128; any other value is unsupported and rejected with a $error at elaboration)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  plaintext/key pair offered
in_ready  output  1  engine can accept a block
in_data  input  128  plaintext, byte 0 = bits [127:120]
in_key  input  128  cipher key, same byte order
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts ciphertext
out_data  output  128  ciphertext
busy  output  1  high in ROUND or FINAL

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, round counter rc=0, state and key registers=0.
- rst is sampled only on the clk edge. Asserting rst mid-operation discards the block in flight; no output is produced for it.
- FSM states are IDLE, ROUND, FINAL and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: st <= in_data^in_key, key <= in_key, rc <= 1, go to ROUND.
- ROUND:
  - Each cycle: key <= RoundKeyGenerator(rc,key); st <= MixColumns(ShiftRows(SubBytes(st)))^next_key; rc <= rc+1.
  - When rc==9 at the edge, go to FINAL with rc=10.
- FINAL:
  - key <= RoundKeyGenerator(10,key); out_data <= ShiftRows(SubBytes(st))^next_key.
  - out_valid <= 1; go to DONE.
- DONE:
  - out_valid=1 and out_data is held stable until out_ready.
  - On out_valid&out_ready: out_valid <= 0, go to IDLE.
- in_ready=1 only in IDLE. There is no overlap between blocks.
- Throughput: one block per 12 cycles plus output stall cycles.
- Latency: accept edge at cycle 0, out_valid high after the edge at cycle 11 (10 round edges follow the accept edge). Exactly 11 edges from accept to out_valid.
- rc is 4 bits and is the only round index passed to RoundKeyGenerator; valid values are 1..10. rc never wraps.
- in_data/in_key are sampled only on the accept edge; changes while busy are ignored.
- out_ready while out_valid=0 has no effect.
- Back-to-back operation: an output handshake in DONE returns to IDLE. The next input is accepted at the earliest on the following cycle. There is no same-cycle output+input.

Optional Feature:
Macro AES_PERF_CNT_EN.
- Defined:
  - Adds output port blk_cnt [31:0]: count of completed output handshakes.
  - Reset value 0; increments on out_valid&out_ready; wraps 0xFFFFFFFF -> 0.
  - Adds output port stall_cnt [31:0]: cycles in DONE with out_ready=0; saturates at 0xFFFFFFFF.
- Undefined: neither port nor the counters exist. Datapath timing is identical in both builds.

Decomposition:
- Package aes_pkg:
  - constants AES_BLK_W=128, AES_NR=10, RC_W=4
  - state enum {IDLE,ROUND,FINAL,DONE}
  - byte-order helper function
- Sub-module aes_final_round: SubBytes+ShiftRows+AddRoundKey, no MixColumns. It reuses ByteSubstitution and ShiftRows.
- RoundKeyGenerator, ByteSubstitution, ShiftRows and MixColumns are instantiated directly in the engine. The key schedule is never duplicated.

Test Plan:
- FIPS-197 App.B: in_data=3243f6a8885a308d313198a2e0370734, in_key=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_data=3925841d02dc09fbdc118597196a0b32, out_valid exactly 11 edges after accept.
- FIPS-197 App.C.1: in_data=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f, out_ready held 0 for 5 cycles -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a stable, out_valid=1 through the stall, in_ready=0 until handshake.
- Input changes while busy: accept App.B vector, then drive in_data=ffff..ff with in_valid=1 during ROUND -> result still 3925841d..., second block accepted only after return to IDLE.
- Reset mid-operation: assert rst at rc=5 for 1 cycle -> next edge out_valid=0, busy=0, in_ready=1; a subsequent App.C.1 block produces 69c4e0d8... with no stale output.
- Back-to-back: two blocks (App.B then App.C.1) with in_valid held high and out_ready=1 -> two outputs in order, second accept one cycle after first output handshake.
- AES_PERF_CNT_EN defined: 3 blocks, 4 stall cycles on block 2 -> blk_cnt=3, stall_cnt=4. Preload blk_cnt=0xFFFFFFFF via force -> wraps to 0 on the next handshake.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state encoding and GF(2^8) helpers
// used by the iterative engine and its round primitives.
package aes_pkg;
    localparam int AES_BLK_W = 128;
    localparam int AES_NR    = 10;
    localparam int RC_W      = 4;

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2, DONE = 2'd3} aes_state_e;

    // Byte 0 is the most significant byte of a block (FIPS-197 input order).
    function automatic logic [7:0] blk_byte(input logic [AES_BLK_W-1:0] blk, input int idx);
        return blk[AES_BLK_W-1-8*idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [RC_W-1:0] rc);
        case (rc)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction
endpackage

// File: rtl/aes_final_round.sv
// Last AES round: SubBytes, ShiftRows and AddRoundKey with no MixColumns.
module aes_final_round import aes_pkg::*; (
    input  logic [AES_BLK_W-1:0] state_i,
    input  logic [AES_BLK_W-1:0] rkey_i,
    output logic [AES_BLK_W-1:0] state_o
);
    logic [AES_BLK_W-1:0] sb, sr;

    ByteSubstitution u_sb (.state_i(state_i), .state_o(sb));
    ShiftRows        u_sr (.state_i(sb),      .state_o(sr));

    assign state_o = sr ^ rkey_i;
endmodule

// File: rtl/aes_round_prims.sv
// Combinational AES round primitives: SubBytes, ShiftRows, MixColumns and
// the on-the-fly round key generator.
module ByteSubstitution import aes_pkg::*; (
    input  logic [AES_BLK_W-1:0] state_i,
    output logic [AES_BLK_W-1:0] state_o
);
    for (genvar i = 0; i < 16; i++) begin : g_sb
        assign state_o[8*i +: 8] = sbox(state_i[8*i +: 8]);
    end
endmodule

module ShiftRows import aes_pkg::*; (
    input  logic [AES_BLK_W-1:0] state_i,
    output logic [AES_BLK_W-1:0] state_o
);
    // Byte 4c+r is row r of column c; row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign state_o[AES_BLK_W-1-8*(4*c+r) -: 8] = blk_byte(state_i, 4*((c+r)%4)+r);
        end
    end
endmodule

module MixColumns import aes_pkg::*; (
    input  logic [AES_BLK_W-1:0] state_i,
    output logic [AES_BLK_W-1:0] state_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = state_i[AES_BLK_W-1-32*c -: 32];
        assign state_o[AES_BLK_W-1-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
endmodule

module RoundKeyGenerator import aes_pkg::*; (
    input  logic [RC_W-1:0]      rc_i,
    input  logic [AES_BLK_W-1:0] key_i,
    output logic [AES_BLK_W-1:0] key_o
);
    logic [31:0] w0, w1, w2, w3, rot, tmp;
    logic [31:0] k0, k1, k2, k3;

    assign {w0, w1, w2, w3} = key_i;
    assign rot = {w3[23:0], w3[31:24]};
    assign tmp = {sbox(rot[31:24]) ^ rcon(rc_i), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign k0 = w0 ^ tmp;
    assign k1 = w1 ^ k0;
    assign k2 = w2 ^ k1;
    assign k3 = w3 ^ k2;
    assign key_o = {k0, k1, k2, k3};
endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor, one round per cycle behind valid/ready handshakes.
// Define AES_PERF_CNT_EN to add the blk_cnt / stall_cnt performance counters.
module aes128_enc_iter import aes_pkg::*; #(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic [AES_BLK_W-1:0] in_key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 busy
`ifdef AES_PERF_CNT_EN
    ,
    output logic [31:0]          blk_cnt,
    output logic [31:0]          stall_cnt
`endif
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ROUND = ROUND;
    localparam logic [1:0] S_FINAL = FINAL;
    localparam logic [1:0] S_DONE  = DONE;

    if (NR != AES_NR) begin : g_nr_check
        $error("aes128_enc_iter: NR=%0d unsupported, AES-128 needs 10", NR);
    end

    logic [1:0]           state_q, state_d;
    logic [RC_W-1:0]      rc_q, rc_d;
    logic [AES_BLK_W-1:0] st_q, st_d, key_q, key_d, out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic [AES_BLK_W-1:0] key_nxt, sb_st, sr_st, mc_st, fin_st;

    // A single key generator serves both ROUND and FINAL; rc selects the rcon.
    RoundKeyGenerator u_rkg (.rc_i(rc_q), .key_i(key_q), .key_o(key_nxt));
    ByteSubstitution  u_sb  (.state_i(st_q),  .state_o(sb_st));
    ShiftRows         u_sr  (.state_i(sb_st), .state_o(sr_st));
    MixColumns        u_mc  (.state_i(sr_st), .state_o(mc_st));
    aes_final_round   u_fin (.state_i(st_q), .rkey_i(key_nxt), .state_o(fin_st));

    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        st_d        = st_q;
        key_d       = key_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                st_d    = in_data ^ in_key;
                key_d   = in_key;
                rc_d    = RC_W'(1);
                state_d = S_ROUND;
            end
            S_ROUND: begin
                key_d = key_nxt;
                st_d  = mc_st ^ key_nxt;
                rc_d  = rc_q + 1'b1;
                if (rc_q == RC_W'(AES_NR - 1)) state_d = S_FINAL;
            end
            S_FINAL: begin
                key_d       = key_nxt;
                out_d       = fin_st;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rc_q        <= '0;
            st_q        <= '0;
            key_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            st_q        <= st_d;
            key_q       <= key_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_ROUND) || (state_q == S_FINAL);
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

`ifdef AES_PERF_CNT_EN
    logic [31:0] blk_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_valid_q && out_ready) blk_cnt_q <= blk_cnt_q + 32'd1;
            if ((state_q == S_DONE) && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign blk_cnt   = blk_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_aes128_enc_iter.sv
// Self-checking bench for aes128_enc_iter: FIPS-197 vectors, handshake corner
// cases and randomized blocks against a table-driven AES-128 reference model.
module tb_aes128_enc_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_PERF_CNT_EN
    logic [31:0]  blk_cnt;
    logic [31:0]  stall_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] sb[256];

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes128_enc_iter dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef AES_PERF_CNT_EN
        , .blk_cnt(blk_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input int m);
        return (m == 2) ? xt(a) : (xt(a) ^ a);
    endfunction

    // Classic generator walk: p steps through powers of 3, q through powers of 1/3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   w[44][4];
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   tmp[4];
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = key[127-8*(4*i+j) -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp[0] = sb[w[i-1][1]] ^ rc;
                tmp[1] = sb[w[i-1][2]];
                tmp[2] = sb[w[i-1][3]];
                tmp[3] = sb[w[i-1][0]];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][i%4];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i + 4*(i%4)) % 16]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    s[4*c]   = gm(t[4*c], 2) ^ gm(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1], 2) ^ gm(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 2) ^ gm(t[4*c+3], 3);
                    s[4*c+3] = gm(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 2);
                end
            end else begin
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][i%4];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Returns at the negedge just after the accept edge.
    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rnd128();
        in_key   = rnd128();
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp, input int stall, input string tag);
        int n;
        out_ready = (stall == 0);
        send(pt, key);
        chk({tag, "_busy"}, {busy, in_ready}, 2'b10);
        wait_out(n);
        // Edges counted from the accept edge through the edge raising out_valid.
        chk({tag, "_latency"}, n + 1, 11);
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_stall"}, {out_valid, in_ready, busy, out_data}, {3'b100, exp});
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk({tag, "_data"}, out_data, exp);
        @(negedge clk);
        chk({tag, "_release"}, {out_valid, in_ready}, 2'b01);
        out_ready = 1'b0;
    endtask

    task automatic b2b(input logic [127:0] pt1, input logic [127:0] k1, input logic [127:0] e1,
                       input logic [127:0] pt2, input logic [127:0] k2, input logic [127:0] e2,
                       input string tag);
        int n;
        out_ready = 1'b1;
        send(pt1, k1);
        in_valid = 1'b1;
        in_data  = pt2;
        in_key   = k2;
        wait_out(n);
        chk({tag, "_first"}, out_data, e1);
        chk({tag, "_no_accept"}, in_ready, 0);
        @(negedge clk);
        chk({tag, "_gap"}, {busy, in_ready, out_valid}, 3'b010);
        @(negedge clk);
        chk({tag, "_accept2"}, {busy, in_ready}, 2'b10);
        in_valid = 1'b0;
        in_data  = rnd128();
        in_key   = rnd128();
        wait_out(n);
        chk({tag, "_latency2"}, n + 1, 11);
        chk({tag, "_second"}, out_data, e2);
        @(negedge clk);
        chk({tag, "_release"}, out_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] pt, key, k2;
        build_sbox();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        run_block(B_PT, B_KEY, B_CT, 0, "fips_b");
        run_block(C_PT, C_KEY, C_CT, 5, "fips_c1_stall");

        k2 = rnd128();
        b2b(B_PT, B_KEY, B_CT, {128{1'b1}}, k2, aes_ref({128{1'b1}}, k2), "busy_ignore");
        b2b(B_PT, B_KEY, B_CT, C_PT, C_KEY, C_CT, "back2back");

        // Reset while the round counter sits at 5.
        out_ready = 1'b1;
        send(rnd128(), rnd128());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_state", {out_valid, busy, in_ready}, 3'b001);
        chk("midrst_data", out_data, 0);
        repeat (12) @(negedge clk);
        chk("midrst_no_stale", out_valid, 0);
        run_block(C_PT, C_KEY, C_CT, 0, "midrst_c1");

        for (int b = 0; b < 6; b++) begin
            pt  = rnd128();
            key = rnd128();
            run_block(pt, key, aes_ref(pt, key), $urandom_range(0, 3), "random");
        end

`ifdef AES_PERF_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("pc_reset", {blk_cnt, stall_cnt}, 64'd0);
        run_block(B_PT, B_KEY, B_CT, 0, "pc_blk1");
        run_block(C_PT, C_KEY, C_CT, 4, "pc_blk2");
        pt  = rnd128();
        key = rnd128();
        run_block(pt, key, aes_ref(pt, key), 0, "pc_blk3");
        chk("pc_blk_cnt", blk_cnt, 3);
        chk("pc_stall_cnt", stall_cnt, 4);
        force dut.blk_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.blk_cnt_q;
        chk("pc_preload", blk_cnt, 32'hFFFF_FFFF);
        run_block(C_PT, C_KEY, C_CT, 0, "pc_blk4");
        chk("pc_wrap", blk_cnt, 0);
        chk("pc_stall_hold", stall_cnt, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
